// File: rtl/maxpooling_mul_arbiter.sv
// maxpooling_mul_arbiter: several requesters share one pipelined multiplier.
// A round-robin arbiter issues at most one operation per cycle. An id tag
// pipeline tracks each operation through the multiplier. A single response
// port can stall the multiplier through its clock enable.
// Optional build macro MAXPOOL_MUL_ARB_PERF_EN adds two outputs,
// perf_issued and perf_stall.
module maxpooling_mul_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DIN0_WIDTH = 62,
  parameter int DIN1_WIDTH = 32,
  parameter int DOUT_WIDTH = 64,
  parameter int MUL_LAT    = 4,
  parameter int ID_W       = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                          mul_ce,
  output logic [DIN0_WIDTH-1:0]         mul_din0,
  output logic [DIN1_WIDTH-1:0]         mul_din1,
  input  logic [DOUT_WIDTH-1:0]         mul_dout,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DOUT_WIDTH-1:0]         rsp_dout
`ifdef MAXPOOL_MUL_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_issued,
  output logic [31:0]                   perf_stall
`endif
);

  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [DIN0_WIDTH-1:0] din0_q, din0_d;
  logic [DIN1_WIDTH-1:0] din1_q, din1_d;
  logic                  tag_v_q  [MUL_LAT+1];
  logic [ID_W-1:0]       tag_id_q [MUL_LAT+1];

  logic                  hi_hit, lo_hit;
  logic [ID_W-1:0]       hi_id, lo_id;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic                  issue;

  // A blocked response freezes the whole multiplier together with its tags.
  assign mul_ce    = !(rsp_valid && !rsp_ready);
  assign rsp_valid = tag_v_q[MUL_LAT];
  assign rsp_id    = tag_id_q[MUL_LAT];
  assign rsp_dout  = mul_dout;
  assign mul_din0  = din0_q;
  assign mul_din1  = din1_q;

  // Round-robin pick: the lowest valid index at or above the pointer wins.
  // If there is none, the lowest valid index overall wins (wrap-around).
  always_comb begin
    hi_hit = 1'b0;
    hi_id  = '0;
    lo_hit = 1'b0;
    lo_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_hit = 1'b1;
        lo_id  = ID_W'(i);
      end
      if (req_valid[i] && (i >= int'(ptr_q))) begin
        hi_hit = 1'b1;
        hi_id  = ID_W'(i);
      end
    end
    grant_any = lo_hit;
    grant_id  = hi_hit ? hi_id : lo_id;
  end

  // No grant while the pipeline is stalled or while reset is asserted.
  assign issue = grant_any && mul_ce && reset_n;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = issue && (grant_id == ID_W'(gi));
  end

  // Next pointer and next operands. Both hold unless an op is issued.
  always_comb begin
    ptr_d  = ptr_q;
    din0_d = din0_q;
    din1_d = din1_q;
    if (issue) begin
      ptr_d  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      din0_d = req_din0[int'(grant_id) * DIN0_WIDTH +: DIN0_WIDTH];
      din1_d = req_din1[int'(grant_id) * DIN1_WIDTH +: DIN1_WIDTH];
    end
  end

  // Round-robin pointer and the registered multiplier operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      din0_q <= '0;
      din1_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      din0_q <= din0_d;
      din1_q <= din1_d;
    end
  end

  // Tag stage 0 is loaded alongside the operand registers. Stages 1..MUL_LAT
  // follow the multiplier's internal stages, so the last tag lines up with
  // mul_dout.
  for (genvar gi = 0; gi <= MUL_LAT; gi++) begin : g_tag
    logic            v_d;
    logic [ID_W-1:0] id_d;
    if (gi == 0) begin : g_head
      assign v_d  = issue;
      assign id_d = grant_id;
    end else begin : g_body
      assign v_d  = tag_v_q[gi-1];
      assign id_d = tag_id_q[gi-1];
    end
    // Tags advance only on enabled edges, exactly like the multiplier.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        tag_v_q[gi]  <= 1'b0;
        tag_id_q[gi] <= '0;
      end else if (mul_ce) begin
        tag_v_q[gi]  <= v_d;
        tag_id_q[gi] <= id_d;
      end
    end
  end

`ifdef MAXPOOL_MUL_ARB_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  // Free-running counts of accepted ops and stalled cycles. Both wrap at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (issue)   perf_issued_q <= perf_issued_q + 32'd1;
      if (!mul_ce) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
